// File: rtl/mul_add_unit.sv
// Purpose: unsigned multiply-add datapath for one systolic PE, plus a registered copy of the sum.
// Latency: mul_out/sum_out/flags are combinational (0 cycles); sum_q_out/ovf_q_out/valid_q_out are 1 cycle.
// Backpressure: none; en_in gates capture, and valid_q_out pulses once per captured sample.
//
// Ports:
//   clk_in, nrst_in        : clock (rising edge), asynchronous active-low reset
//   en_in                  : capture enable for the registered stage
//   weight_in, feature_in  : multiplicand / multiplier (unsigned, WIDTH bits)
//   partial_sum_in         : addend (unsigned, WIDTH bits)
//   mul_out, mul_ovf_out   : truncated product and "product did not fit" flag
//   sum_out, add_carry_out : partial_sum_in + mul_out (mod 2^WIDTH) and its carry
//   sum_q_out, ovf_q_out   : registered sum and combined overflow, held while en_in=0
//   valid_q_out            : registered en_in
module mul_add_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             nrst_in,
  input  logic             en_in,
  input  logic [WIDTH-1:0] weight_in,
  input  logic [WIDTH-1:0] feature_in,
  input  logic [WIDTH-1:0] partial_sum_in,
  output logic [WIDTH-1:0] mul_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             mul_ovf_out,
  output logic             add_carry_out,
  output logic [WIDTH-1:0] sum_q_out,
  output logic             ovf_q_out,
  output logic             valid_q_out
);

  logic [2*WIDTH-1:0] full_prod;
  logic [WIDTH:0]     full_sum;

  // Operands are zero-extended so the multiply is explicitly 2*WIDTH wide.
  assign full_prod   = {{WIDTH{1'b0}}, weight_in} * {{WIDTH{1'b0}}, feature_in};
  assign mul_out     = full_prod[WIDTH-1:0];
  assign mul_ovf_out = |full_prod[2*WIDTH-1:WIDTH];

  // The addend is the truncated product, so high product bits never reach the sum.
  assign full_sum      = {1'b0, partial_sum_in} + {1'b0, mul_out};
  assign sum_out       = full_sum[WIDTH-1:0];
  assign add_carry_out = full_sum[WIDTH];

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      sum_q_out   <= '0;
      ovf_q_out   <= 1'b0;
      valid_q_out <= 1'b0;
    end else begin
      valid_q_out <= en_in;
      if (en_in) begin
        sum_q_out <= sum_out;
        ovf_q_out <= mul_ovf_out | add_carry_out;
      end
    end
  end

endmodule

// File: tb/tb_mul_add_unit.sv
module tb_mul_add_unit;

  localparam int WIDTH = 8;

  logic             clk_in;
  logic             nrst_in;
  logic             en_in;
  logic [WIDTH-1:0] weight_in;
  logic [WIDTH-1:0] feature_in;
  logic [WIDTH-1:0] partial_sum_in;
  logic [WIDTH-1:0] mul_out;
  logic [WIDTH-1:0] sum_out;
  logic             mul_ovf_out;
  logic             add_carry_out;
  logic [WIDTH-1:0] sum_q_out;
  logic             ovf_q_out;
  logic             valid_q_out;

  int n_tests;
  int n_fail;

  mul_add_unit #(.WIDTH(WIDTH)) dut (
    .clk_in         (clk_in),
    .nrst_in        (nrst_in),
    .en_in          (en_in),
    .weight_in      (weight_in),
    .feature_in     (feature_in),
    .partial_sum_in (partial_sum_in),
    .mul_out        (mul_out),
    .sum_out        (sum_out),
    .mul_ovf_out    (mul_ovf_out),
    .add_carry_out  (add_carry_out),
    .sum_q_out      (sum_q_out),
    .ovf_q_out      (ovf_q_out),
    .valid_q_out    (valid_q_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0] w;
    logic [7:0] f;
    logic [7:0] p;
    logic [7:0] e_mul;
    logic [7:0] e_sum;
    logic       e_ovf;
    logic       e_carry;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] w, input logic [7:0] f, input logic [7:0] p, input logic en);
    weight_in      = w;
    feature_in     = f;
    partial_sum_in = p;
    en_in          = en;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // w, f, p, mul, sum, ovf, carry (all hand computed)
    vecs[0] = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h05, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 8'hFF, 8'h02, 8'hFF, 8'h01, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'hA5, 8'h37, 8'h00, 8'h37, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 8'h01, 8'h01, 8'h02, 1'b1, 1'b0};
    vecs[5] = '{8'h5A, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h0F, 8'h11, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h0F, 8'h11, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1};
    vecs[8] = '{8'h12, 8'h34, 8'h56, 8'hA8, 8'hFE, 1'b1, 1'b0};
    vecs[9] = '{8'h03, 8'h05, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};

    // Reset state, with en_in high and the clock running.
    nrst_in = 1'b0;
    drive(8'h02, 8'h01, 8'h03, 1'b1);
    #1;
    check("reset_sum_q", sum_q_out, 0);
    check("reset_ovf_q", ovf_q_out, 0);
    check("reset_valid_q", valid_q_out, 0);
    check("reset_comb_sum", sum_out, 8'h05);
    tick();
    tick();
    check("reset_hold_sum_q", sum_q_out, 0);
    check("reset_hold_valid_q", valid_q_out, 0);

    // Release between edges.
    @(negedge clk_in);
    nrst_in = 1'b1;

    // Table: combinational results, then 1-cycle registered capture.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      drive(vecs[i].w, vecs[i].f, vecs[i].p, 1'b1);
      #1;
      check($sformatf("v%0d_mul", i), mul_out, vecs[i].e_mul);
      check($sformatf("v%0d_sum", i), sum_out, vecs[i].e_sum);
      check($sformatf("v%0d_mul_ovf", i), mul_ovf_out, vecs[i].e_ovf);
      check($sformatf("v%0d_carry", i), add_carry_out, vecs[i].e_carry);
      tick();
      check($sformatf("v%0d_sum_q", i), sum_q_out, vecs[i].e_sum);
      check($sformatf("v%0d_ovf_q", i), ovf_q_out, vecs[i].e_ovf | vecs[i].e_carry);
      check($sformatf("v%0d_valid_q", i), valid_q_out, 1);
    end

    // Enable gating: capture 0x05, then hold across 3 edges with new inputs.
    @(negedge clk_in);
    drive(8'h02, 8'h01, 8'h03, 1'b1);
    tick();
    check("gate_capture", sum_q_out, 8'h05);
    drive(8'h02, 8'h02, 8'h05, 1'b0);
    #1;
    check("gate_comb_sum", sum_out, 8'h09);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("gate_hold_sum_q_%0d", k), sum_q_out, 8'h05);
      check($sformatf("gate_valid_q_%0d", k), valid_q_out, 0);
      check($sformatf("gate_ovf_q_%0d", k), ovf_q_out, 0);
    end

    // Mid-cycle change is not captured; only the value at the edge matters.
    @(negedge clk_in);
    drive(8'hFF, 8'hFF, 8'h00, 1'b1);
    #2;
    drive(8'h01, 8'h01, 8'h01, 1'b1);
    tick();
    check("midchange_sum_q", sum_q_out, 8'h02);
    check("midchange_ovf_q", ovf_q_out, 0);

    // Async reset mid-operation.
    @(negedge clk_in);
    drive(8'h02, 8'h01, 8'h03, 1'b1);
    tick();
    check("arst_pre_sum_q", sum_q_out, 8'h05);
    en_in = 1'b0;
    #2;
    nrst_in = 1'b0;
    #1;
    check("arst_sum_q", sum_q_out, 0);
    check("arst_ovf_q", ovf_q_out, 0);
    check("arst_valid_q", valid_q_out, 0);
    check("arst_comb_sum", sum_out, 8'h05);
    drive(8'h03, 8'h03, 8'h01, 1'b1);
    #1;
    check("arst_comb_mul_track", mul_out, 8'h09);
    check("arst_comb_sum_track", sum_out, 8'h0A);
    tick();
    check("arst_edge_sum_q", sum_q_out, 0);
    check("arst_edge_valid_q", valid_q_out, 0);
    @(negedge clk_in);
    nrst_in = 1'b1;
    tick();
    check("post_arst_sum_q", sum_q_out, 8'h0A);
    check("post_arst_valid_q", valid_q_out, 1);
    en_in = 1'b0;
    tick();
    check("post_arst_valid_drop", valid_q_out, 0);
    check("post_arst_hold", sum_q_out, 8'h0A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_add_unit.md
Name: mul_add_unit

Overview:
- Arithmetic datapath for one systolic processing element.
- Combinationally forms product = weight × feature and sum = partial_sum_in + product, both truncated to WIDTH bits.
- Also provides a registered copy of the sum, with a valid flag and overflow flags.
- Sits between the PE weight register and the partial-sum output mux. The combinational outputs replace the standalone multiplier and adder; the registered outputs serve pipelined arrays.

Parameters:
- WIDTH, 8, bit width of every data operand and result.

Ports:
- clk_in  input  1  single clock, rising edge.
- nrst_in  input  1  asynchronous active-low reset.
- en_in  input  1  capture enable for the registered stage.
- weight_in  input  WIDTH  multiplicand (stored PE weight).
- feature_in  input  WIDTH  multiplier (feature value).
- partial_sum_in  input  WIDTH  addend (incoming partial sum).
- mul_out  output  WIDTH  combinational product, low WIDTH bits.
- sum_out  output  WIDTH  combinational partial_sum_in + mul_out, low WIDTH bits.
- mul_ovf_out  output  1  combinational flag: full 2·WIDTH product ≥ 2^WIDTH.
- add_carry_out  output  1  combinational carry out of the WIDTH-bit add.
- sum_q_out  output  WIDTH  registered sum_out.
- ovf_q_out  output  1  registered (mul_ovf_out OR add_carry_out).
- valid_q_out  output  1  registered en_in.

Behaviour:
- All operands are unsigned.
- Product:
  - full = weight_in × feature_in, 2·WIDTH bits.
  - mul_out = full[WIDTH-1:0].
  - mul_ovf_out = |full[2·WIDTH-1:WIDTH].
- Sum:
  - {add_carry_out, sum_out} = partial_sum_in + mul_out, WIDTH+1 bits.
  - The addend is the truncated product, not the full product.
  - Wrap-around is modulo 2^WIDTH; no saturation.
- mul_out, sum_out, mul_ovf_out and add_carry_out:
  - Purely combinational, zero latency.
  - Independent of clk_in, nrst_in and en_in.
  - Settle in the same delta/cycle as the inputs change.
- Registered stage on rising clk_in edge:
  - If en_in=1: sum_q_out ← sum_out; ovf_q_out ← mul_ovf_out | add_carry_out; valid_q_out ← 1.
  - If en_in=0: sum_q_out and ovf_q_out hold; valid_q_out ← 0.
- Latency from inputs to sum_q_out: exactly 1 clock.
- valid_q_out is high for exactly one cycle per captured sample.
- Reset (nrst_in=0):
  - Immediately, without waiting for a clock edge: sum_q_out=0, ovf_q_out=0, valid_q_out=0.
  - Registered outputs stay cleared while nrst_in is low, regardless of en_in or clock activity.
  - Combinational outputs keep tracking the inputs during reset.
- Reset deassertion:
  - The first capture occurs at the first rising edge with nrst_in=1 and en_in=1.
  - Deassertion coincident with a clock edge must not capture; the register stays 0 until the next edge.
- Zero operand: if weight_in=0 or feature_in=0, then mul_out=0, mul_ovf_out=0 and sum_out=partial_sum_in.
- Maximum operands (WIDTH=8): weight=feature=0xFF gives full=0xFE01, mul_out=0x01, mul_ovf_out=1.
- Mid-operation input changes between edges are not captured; only values present at the edge matter.
- No internal state besides the three registered outputs.
- No X propagation from en_in when nrst_in=0.
- Synthesizable; any multiplier structure is acceptable (array, shift-add or operator).

Test Plan:
- Basic MAC: weight=0x02, feature=0x01, partial_sum=0x03 → mul_out=0x02, sum_out=0x05, flags 0. With en_in=1, after one edge sum_q_out=0x05 and valid_q_out=1.
- Product truncation: weight=0x10, feature=0x10, partial_sum=0x00 → full 0x0100, mul_out=0x00, mul_ovf_out=1, sum_out=0x00. After the edge, ovf_q_out=1.
- Add wrap: weight=0x01, feature=0xFF, partial_sum=0x02 → mul_out=0xFF, sum_out=0x01, add_carry_out=1, mul_ovf_out=0.
- Zero/max sweep:
  - weight=0 with any feature → mul_out=0 and sum_out=partial_sum.
  - weight=feature=0xFF, partial_sum=0x01 → mul_out=0x01, sum_out=0x02, mul_ovf_out=1.
- Enable gating: capture 0x05, then drop en_in and change inputs to produce sum_out=0x09. For 3 edges, sum_q_out stays 0x05 and valid_q_out=0.
- Async reset mid-operation: with sum_q_out=0x05, assert nrst_in=0 between edges.
  - sum_q_out, ovf_q_out and valid_q_out go to 0 immediately.
  - Combinational outputs keep tracking the inputs.
  - After release, the next enabled edge captures the new sum.
